// File: rtl/b10_vote_sink.sv
// Sink for the b10 voting controller's RTS/CTS port. It captures vote vectors into a FIFO,
// keeps a saturating tally per vote bit, and flags request timeouts.
module b10_vote_sink #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cts,
    input  logic [3:0]       v_out,
    output logic             rts,
    output logic [3:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             full,
    output logic [CNT_W-1:0] tally_0,
    output logic [CNT_W-1:0] tally_1,
    output logic [CNT_W-1:0] tally_2,
    output logic [CNT_W-1:0] tally_3,
    input  logic             clear_tally,
    output logic             timeout_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW:0] DepthC = (PW + 1)'(DEPTH);
    localparam logic [TW-1:0] TmoLast = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] TallyMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRel
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [3:0]       mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;
    logic [CNT_W-1:0] tally_q [4];
    logic [CNT_W-1:0] tally_d [4];
    logic             err_q, err_d;
    logic             push, pop, tmo_hit;

    assign push    = (state_q == StReq) && cts;
    assign pop     = (cnt_q != '0) && data_ready;
    // Expiry counts only on a cycle without CTS, so a late CTS still wins.
    assign tmo_hit = (TIMEOUT != 0) && (state_q == StReq) && !cts && (tmo_q == TmoLast);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (enable && (cnt_q < DepthC)) begin
                    state_d = StReq;
                    tmo_d   = '0;
                end
            end
            StReq: begin
                if (cts) begin
                    state_d = StRel;
                end else if (tmo_hit || !enable) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRel: begin
                if (!cts) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= v_out;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tally_d[i] = tally_q[i];
            if (clear_tally) begin
                tally_d[i] = '0;
            end else if (push && v_out[i] && (tally_q[i] != TallyMax)) begin
                tally_d[i] = tally_q[i] + 1'b1;
            end
        end
        err_d = err_q;
        if (clear_tally) begin
            err_d = 1'b0;
        end else if (tmo_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                tally_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                tally_q[i] <= tally_d[i];
            end
            err_q <= err_d;
        end
    end

    assign rts         = (state_q == StReq);
    assign data_out    = mem_q[rd_q];
    assign data_valid  = (cnt_q != '0);
    assign full        = (cnt_q == DepthC);
    assign tally_0     = tally_q[0];
    assign tally_1     = tally_q[1];
    assign tally_2     = tally_q[2];
    assign tally_3     = tally_q[3];
    assign timeout_err = err_q;

endmodule

// File: tb/tb_b10_vote_sink.sv
// Directed and randomized bench for b10_vote_sink. It compares every cycle against a
// queue-based reference model of the request/capture protocol.
module tb_b10_vote_sink;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 2;
    localparam int unsigned TMO   = 15;
    localparam int          TMAX  = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0, cts = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic [3:0]      vout = '0;
    logic            rts, data_valid, full, timeout_err;
    logic [3:0]      data_out;
    logic [CNTW-1:0] tally_0, tally_1, tally_2, tally_3;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 waiting for CTS release.
    int         ph = 0;
    int         wt = 0;
    logic [3:0] q[$];
    int         tl[4];
    bit         er = 1'b0;

    always #5 clk = ~clk;

    b10_vote_sink #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNTW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en),
        .cts         (cts),
        .v_out       (vout),
        .rts         (rts),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (rdy),
        .full        (full),
        .tally_0     (tally_0),
        .tally_1     (tally_1),
        .tally_2     (tally_2),
        .tally_3     (tally_3),
        .clear_tally (clr),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0;
        wt = 0;
        q.delete();
        for (int i = 0; i < 4; i++) tl[i] = 0;
        er = 1'b0;
    endtask

    task automatic model_edge();
        int sz0;
        bit mpush, mpop, hit;
        sz0   = q.size();
        mpop  = (sz0 > 0) && rdy;
        mpush = (ph == 1) && cts;
        hit   = (ph == 1) && !cts && (TMO > 0) && (wt + 1 == TMO);
        if (clr) begin
            for (int i = 0; i < 4; i++) tl[i] = 0;
            er = 1'b0;
        end else begin
            if (hit) er = 1'b1;
            if (mpush) begin
                for (int i = 0; i < 4; i++) begin
                    if (vout[i] && tl[i] < TMAX) tl[i]++;
                end
            end
        end
        if (mpop) void'(q.pop_front());
        if (mpush) q.push_back(vout);
        case (ph)
            0: if (en && sz0 < DEPTH) begin ph = 1; wt = 0; end
            1: begin
                if (cts) ph = 2;
                else if (hit || !en) ph = 0;
                else wt++;
            end
            default: if (!cts) ph = 0;
        endcase
    endtask

    task automatic check_all();
        check("rts", rts, ph == 1);
        check("data_valid", data_valid, q.size() > 0);
        check("full", full, q.size() == DEPTH);
        if (q.size() > 0) check("data_out", data_out, q[0]);
        check("tally_0", tally_0, tl[0]);
        check("tally_1", tally_1, tl[1]);
        check("tally_2", tally_2, tl[2]);
        check("tally_3", tally_3, tl[3]);
        check("timeout_err", timeout_err, er);
    endtask

    task automatic cyc(input bit e, input bit c, input logic [3:0] v, input bit r, input bit k);
        en   = e;
        cts  = c;
        vout = v;
        rdy  = r;
        clr  = k;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_rts", rts, 0);
        check("rst_valid", data_valid, 0);
        check("rst_full", full, 0);
        check("rst_data_out", data_out, 0);
        check("rst_tally_0", tally_0, 0);
        check("rst_tally_3", tally_3, 0);
        check("rst_err", timeout_err, 0);
        rst_n = 1'b1;

        // Single capture with CTS three cycles after RTS.
        cyc(1, 0, 4'h0, 0, 0);
        check("t1_rts_up", rts, 1);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 1, 4'hA, 0, 0);
        check("t1_rts_drop", rts, 0);
        check("t1_data", data_out, 4'hA);
        check("t1_tally_0", tally_0, 0);
        check("t1_tally_1", tally_1, 1);
        check("t1_tally_2", tally_2, 0);
        check("t1_tally_3", tally_3, 1);
        cyc(0, 0, 4'h0, 0, 0);

        // Fill the FIFO with the consumer stalled.
        for (int n = 0; n < 80 && q.size() < DEPTH; n++) begin
            cyc(1, (ph == 1) && ($urandom_range(0, 1) == 1), 4'($urandom), 0, 0);
        end
        check("t2_full", full, 1);
        for (int n = 0; n < 3; n++) begin
            cyc(1, 0, 4'h0, 0, 0);
            check("t2_rts_held", rts, 0);
        end
        cyc(1, 0, 4'h0, 1, 0);
        check("t2_unfull", full, 0);
        cyc(1, 0, 4'h0, 0, 0);
        check("t2_restart", rts, 1);
        cyc(1, 1, 4'($urandom), 0, 0);
        for (int n = 0; n < 10 && q.size() > 0; n++) cyc(0, 0, 4'h0, 1, 0);
        check("t2_drained", data_valid, 0);
        for (int n = 0; n < 5 && ph != 0; n++) cyc(0, 0, 4'h0, 1, 0);

        // Timeout with CTS held low.
        cyc(1, 0, 4'h0, 1, 0);
        hi = (rts === 1'b1) ? 1 : 0;
        for (int n = 0; n < 40; n++) begin
            cyc(1, 0, 4'h0, 1, 0);
            if (rts === 1'b1) hi++;
            else break;
        end
        check("t3_rts_cycles", hi, 15);
        check("t3_err", timeout_err, 1);
        check("t3_no_push", data_valid, 0);
        cyc(0, 0, 4'h0, 1, 1);
        check("t3_err_clear", timeout_err, 0);

        // Saturation with a 2-bit tally, then clear racing a capture.
        for (int n = 0; n < 4; n++) begin
            cyc(1, 0, 4'h0, 1, 0);
            cyc(1, 1, 4'b0001, 1, 0);
            cyc(0, 0, 4'h0, 1, 0);
        end
        check("t4_saturated", tally_0, 3);
        cyc(1, 0, 4'h0, 1, 0);
        cyc(1, 1, 4'b0001, 1, 1);
        check("t4_clear_wins", tally_0, 0);
        cyc(0, 0, 4'h0, 1, 0);

        // CTS held high for five cycles yields one capture.
        cyc(1, 0, 4'h0, 1, 0);
        for (int n = 0; n < 5; n++) begin
            cyc(1, 1, 4'b0010, 1, 0);
            check("t5_in_rel", rts, 0);
        end
        check("t5_one_capture", tally_1, 1);
        cyc(1, 0, 4'h0, 1, 0);
        check("t5_idle_gap", rts, 0);
        cyc(1, 0, 4'h0, 0, 0);
        check("t5_new_req", rts, 1);

        // Reset mid-request with two entries buffered.
        cyc(1, 1, 4'h3, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 1, 4'h5, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        check("t6_pre_rts", rts, 1);
        check("t6_pre_tally_0", tally_0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rts", rts, 0);
        check("t6_rst_valid", data_valid, 0);
        check("t6_rst_tally_0", tally_0, 0);
        check("t6_rst_tally_1", tally_1, 0);
        check("t6_rst_tally_2", tally_2, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 4'h0, 0, 0);
        check("t6_after_rst", rts, 1);
        cyc(1, 1, 4'h6, 0, 0);
        check("t6_after_data", data_out, 4'h6);

        // Randomized traffic, with periodic stretches where CTS never answers.
        for (int n = 0; n < 900; n++) begin
            bit quiet;
            quiet = ((n / 100) % 3) == 2;
            cyc($urandom_range(0, 7) != 0,
                !quiet && ($urandom_range(0, 3) == 0),
                4'($urandom),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 60) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
